// File: rtl/tff_bank.sv
// tff_bank: bank of WIDTH configurable flip-flops (T / D / JK / masked clear)
// with a registered per-bit change mask and an optional saturating counter of
// bit changes. Optional feature macro: TFF_TOGGLE_CNT_EN (adds tog_cnt and
// makes cnt_clr meaningful).

// Per-bit next-state selector; one instance per bank bit.
module tff_bit (
  input  logic [1:0] mode,
  input  logic       q,
  input  logic       t,
  input  logic       d,
  output logic       q_nxt
);
  // mode 00=T, 01=D, 10=JK (t=J, d=K), 11=clear where t is set
  always_comb begin
    q_nxt = q;
    unique case (mode)
      2'b00:   q_nxt = q ^ t;
      2'b01:   q_nxt = d;
      2'b10:   q_nxt = (t & ~q) | (~d & q);
      default: q_nxt = q & ~t;
    endcase
  end
endmodule

module tff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] toggled
`ifdef TFF_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] tog_cnt
`endif
);

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_bit u_bit (
      .mode  (mode),
      .q     (q[i]),
      .t     (t[i]),
      .d     (d[i]),
      .q_nxt (q_nxt[i])
    );
  end

  assign diff = q_nxt ^ q;
  assign qb   = ~q;

  // State and change mask; en=0 holds q and reports no changes
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      toggled <= '0;
    end else if (en) begin
      q       <= q_nxt;
      toggled <= diff;
    end else begin
      toggled <= '0;
    end
  end

`ifdef TFF_TOGGLE_CNT_EN
  // Popcount is 0..WIDTH; the add is done wide enough that it cannot wrap
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] cnt_max;

  // Count the bits that change this cycle
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PC_W'(diff[i]);
  end

  assign cnt_max = SUM_W'({CNT_W{1'b1}});
  assign sum     = SUM_W'(tog_cnt) + SUM_W'(pc);

  // Saturating change counter; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      tog_cnt <= '0;
    else if (en)
      tog_cnt <= (sum > cnt_max) ? cnt_max[CNT_W-1:0] : sum[CNT_W-1:0];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: doc/tff_bank.md
TFF_BANK -- requirements
Module: tff_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits in the bank (1..32).
REQ-002 Parameter CNT_W, default 16, width of the toggle-event counter.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  cycle enable; when 0, q SHALL hold and toggled SHALL be 0.
REQ-006 mode  input  2  operation select: 00 = T, 01 = D, 10 = JK, 11 = CLR.
REQ-007 t  input  WIDTH  per-bit T input; also serves as J in JK mode and as the clear mask in CLR mode.
REQ-008 d  input  WIDTH  per-bit D input; also serves as K in JK mode.
REQ-009 cnt_clr  input  1  synchronous clear of tog_cnt.
REQ-010 q  output  WIDTH  registered flip-flop state.
REQ-011 qb  output  WIDTH  bitwise complement of q, combinational from q.
REQ-012 toggled  output  WIDTH  registered mask of bits whose q changed on the last edge.
REQ-013 tog_cnt  output  CNT_W  saturating count of bit changes (present only with TFF_TOGGLE_CNT_EN).

Function
REQ-014 Next-state logic with en=1 SHALL be:
- T: q <= q ^ t.
- D: q <= d.
- JK, per bit: j=0,k=0 holds; j=0,k=1 clears; j=1,k=0 sets; j=1,k=1 toggles.
- CLR: q <= q & ~t.
REQ-015 Latency SHALL be one clock; q reflects inputs sampled at the preceding edge.
REQ-016 toggled SHALL equal (q_next ^ q) registered alongside q, and SHALL be all-zero on any cycle with en=0.
REQ-017 tog_cnt SHALL add popcount(q_next ^ q) each enabled cycle; the popcount is 0..WIDTH and is computed at full width before the add.
REQ-018 tog_cnt SHALL saturate at 2^CNT_W-1 and never wrap; a sum that would exceed the maximum SHALL yield the maximum.
REQ-019 cnt_clr=1 SHALL set tog_cnt to 0 on that edge, overriding any same-cycle increment; q and toggled SHALL update normally.
REQ-020 With en=0, tog_cnt SHALL hold unless cnt_clr=1.
REQ-021 Mode changes SHALL take effect on the same cycle they are presented; there is no pipelined mode state.

Reset
REQ-022 rst=1 at an edge SHALL force q=0, toggled=0 and tog_cnt=0, overriding en, mode and cnt_clr.
REQ-023 While in reset, qb SHALL read all-ones.
REQ-024 Reset asserted mid-sequence SHALL discard that cycle's update; the first edge after rst deasserts SHALL operate from q=0.
REQ-025 Reset SHALL count no toggles, even when q was nonzero before reset.

Configuration
REQ-026 Macro TFF_TOGGLE_CNT_EN: when defined, the tog_cnt port and its counter SHALL be compiled in per REQ-017..REQ-020.
REQ-027 When TFF_TOGGLE_CNT_EN is undefined, the tog_cnt port and its counter SHALL be absent, cnt_clr SHALL be ignored, and all other behaviour SHALL be identical.

Verification (WIDTH=4, CNT_W=4, TFF_TOGGLE_CNT_EN defined unless noted)
REQ-028 rst=1 for 2 cycles with en=1, mode=01, d=4'hF -> q=0, qb=4'hF, toggled=0, tog_cnt=0.
REQ-029 After reset, mode=00, t=4'b0101 for 3 enabled cycles -> q sequence 5,0,5; toggled=5 each cycle; tog_cnt=6.
REQ-030 q=4'b0011, mode=10, t=4'b1010, d=4'b0110 -> q=4'b1001, toggled=4'b1010.
REQ-031 tog_cnt=14, mode=00, t=4'hF -> tog_cnt=15; a further toggle cycle keeps tog_cnt=15; cnt_clr=1 together with t=4'hF -> tog_cnt=0 and q inverts.
REQ-032 en=0, mode=01, d=4'hA for 2 cycles from q=3 -> q stays 3, toggled=0, tog_cnt unchanged.
REQ-033 Macro undefined: repeat the REQ-029 stimulus -> identical q and toggled; the tog_cnt port is absent and the build elaborates cleanly.
